// File: rtl/rst_seq_pkg.sv
// Shared encodings and widths for the reset sequencer.
package rst_seq_pkg;

    localparam int CNT_W = 16;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] ST_HOLD      = 3'd2;
    localparam logic [2:0] ST_RELEASE   = 3'd3;
    localparam logic [2:0] ST_DONE      = 3'd4;

    typedef enum logic [2:0] {
        IDLE      = ST_IDLE,
        WAIT_LOCK = ST_WAIT_LOCK,
        HOLD      = ST_HOLD,
        RELEASE   = ST_RELEASE,
        DONE      = ST_DONE
    } state_t;

endpackage

// File: rtl/rst_seq_gen_sync_bit.sv
// Multi-flop synchronizer bringing a single asynchronous bit into the clk domain.
module sync_bit #(
    parameter int STAGES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/rst_seq_gen.sv
// Power-on reset sequencer: waits for a qualified PLL lock, holds all domains
// in reset, then releases them one at a time, lowest index first.
module rst_seq_gen
    import rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES = 3,
    parameter int HOLD_CYC    = 16,
    parameter int GAP_CYC     = 8,
    parameter int NUM_DOM     = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pll_locked,
    input  logic               soft_rst_req,
    output logic [NUM_DOM-1:0] rst_dom,
    output logic               init_done,
    output logic [2:0]         seq_state
);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [2:0]         idx, idx_n, next_idx;
    logic [NUM_DOM-1:0] rst_dom_n;
    logic               init_done_n;
    logic               lock_s;

    sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (pll_locked),
        .q   (lock_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            rst_dom   <= '1;
            init_done <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            rst_dom   <= rst_dom_n;
            init_done <= init_done_n;
        end
    end

    // Lock loss outranks everything once sequencing has started; the final
    // domain release and the DONE entry share one edge so init_done tracks it.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        idx_n       = idx;
        rst_dom_n   = rst_dom;
        init_done_n = init_done;
        next_idx    = idx + 3'd1;

        unique case (state)
            IDLE: begin
                state_n = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_n = HOLD;
                    cnt_n   = HOLD_LOAD;
                    idx_n   = '0;
                end
            end
            HOLD: begin
                if (!lock_s) begin
                    state_n     = WAIT_LOCK;
                    rst_dom_n   = '1;
                    init_done_n = 1'b0;
                end else if (cnt == '0) begin
                    rst_dom_n[0] = 1'b0;
                    idx_n        = '0;
                    if (NUM_DOM == 1) begin
                        state_n     = DONE;
                        init_done_n = 1'b1;
                    end else begin
                        state_n = RELEASE;
                        cnt_n   = GAP_LOAD;
                    end
                end else begin
                    cnt_n = cnt - CNT_ONE;
                end
            end
            RELEASE: begin
                if (!lock_s) begin
                    state_n     = WAIT_LOCK;
                    rst_dom_n   = '1;
                    init_done_n = 1'b0;
                end else if (cnt == '0) begin
                    idx_n = next_idx;
                    for (int k = 0; k < NUM_DOM; k++) begin
                        if (k == int'(next_idx)) begin
                            rst_dom_n[k] = 1'b0;
                        end
                    end
                    if (int'(next_idx) == NUM_DOM - 1) begin
                        state_n     = DONE;
                        init_done_n = 1'b1;
                    end else begin
                        cnt_n = GAP_LOAD;
                    end
                end else begin
                    cnt_n = cnt - CNT_ONE;
                end
            end
            DONE: begin
                if (!lock_s) begin
                    state_n     = WAIT_LOCK;
                    rst_dom_n   = '1;
                    init_done_n = 1'b0;
                end else if (soft_rst_req) begin
                    state_n     = HOLD;
                    cnt_n       = HOLD_LOAD;
                    idx_n       = '0;
                    rst_dom_n   = '1;
                    init_done_n = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign seq_state = state;

endmodule
